// File: rtl/spi_counter_tx.sv
// spi_counter_tx: free-running up/down counter that sends its value over a
// 3-wire SPI master link (cs, sclk, sdo) once per frame, MSB first, then steps.
// Optional build macro SPI_COUNTER_PARITY_EN appends an even-parity bit to
// every frame (frame length WIDTH+1 bits instead of WIDTH).
module spi_counter_tx #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned GAP     = 8,
  parameter bit          CPOL    = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             cs,
  output logic             sclk,
  output logic             sdo,
  output logic             busy,
  output logic             frame_done
);

`ifdef SPI_COUNTER_PARITY_EN
  localparam int unsigned FRAME_N = WIDTH + 1;
`else
  localparam int unsigned FRAME_N = WIDTH;
`endif
  localparam int unsigned SH_W     = FRAME_N - 1;
  localparam int unsigned HALVES   = 2 * FRAME_N;
  localparam int unsigned HALF_W   = $clog2(HALVES);
  localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned GAP_W    = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int unsigned DIV_LAST = CLK_DIV - 1;
  localparam int unsigned GAP_LAST = (GAP > 0) ? GAP - 1 : 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  count_q, count_d;
  logic [SH_W-1:0]   shreg_q, shreg_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [HALF_W-1:0] half_q, half_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              sclk_int_q, sclk_int_d;
  logic              cs_q, cs_d;
  logic              sdo_q, sdo_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic              step;
  logic [FRAME_N-1:0] frame_word;

  // Word transmitted for the current count: data, optionally followed by parity.
`ifdef SPI_COUNTER_PARITY_EN
  assign frame_word = {count_q, ^count_q};
`else
  assign frame_word = count_q;
`endif

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      shreg_q      <= '0;
      div_q        <= '0;
      half_q       <= '0;
      gap_q        <= '0;
      sclk_int_q   <= 1'b0;
      cs_q         <= 1'b1;
      sdo_q        <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      shreg_q      <= shreg_d;
      div_q        <= div_d;
      half_q       <= half_d;
      gap_q        <= gap_d;
      sclk_int_q   <= sclk_int_d;
      cs_q         <= cs_d;
      sdo_q        <= sdo_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Next-state logic: frame sequencing, SCLK generation and bit shifting.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    div_d        = div_q;
    half_d       = half_q;
    gap_d        = gap_q;
    sclk_int_d   = sclk_int_q;
    cs_d         = cs_q;
    sdo_d        = sdo_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    step         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          // Snapshot the count; the frame in flight never sees later loads.
          state_d    = ST_SHIFT;
          sdo_d      = frame_word[FRAME_N-1];
          shreg_d    = frame_word[SH_W-1:0];
          cs_d       = 1'b0;
          busy_d     = 1'b1;
          div_d      = '0;
          half_d     = '0;
          sclk_int_d = 1'b0;
        end
      end

      ST_SHIFT: begin
        if (div_q == DIV_W'(DIV_LAST)) begin
          div_d = '0;
          if (sclk_int_q) begin
            sclk_int_d = 1'b0;
            if (half_q == HALF_W'(HALVES - 1)) begin
              // Last falling edge closes the frame and steps the counter.
              state_d      = (GAP == 0) ? ST_IDLE : ST_GAP;
              cs_d         = 1'b1;
              busy_d       = 1'b0;
              sdo_d        = 1'b0;
              frame_done_d = 1'b1;
              step         = 1'b1;
              gap_d        = '0;
            end else begin
              sdo_d   = shreg_q[SH_W-1];
              shreg_d = shreg_q << 1;
              half_d  = half_q + HALF_W'(1);
            end
          end else begin
            sclk_int_d = 1'b1;
            half_d     = half_q + HALF_W'(1);
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      ST_GAP: begin
        if (gap_q == GAP_W'(GAP_LAST)) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Counter update: a load always beats the frame-end step.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (step) begin
      count_d = up_down ? (count_q + WIDTH'(1)) : (count_q - WIDTH'(1));
    end
  end

  assign count      = count_q;
  assign cs         = cs_q;
  assign sclk       = sclk_int_q ^ CPOL;
  assign sdo        = sdo_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_spi_counter_tx.sv
// Self-checking bench for spi_counter_tx: a negedge monitor decodes SPI frames,
// and each test task compares decoded frames and the counter against the
// behaviour expected from the counter/frame rules.
module tb_spi_counter_tx;

  localparam int unsigned W  = 8;
  localparam int unsigned CD = 2;
  localparam int unsigned GP = 4;
`ifdef SPI_COUNTER_PARITY_EN
  localparam bit          CP = 1'b1;
  localparam int unsigned N  = W + 1;
`else
  localparam bit          CP = 1'b0;
  localparam int unsigned N  = W;
`endif
  localparam int unsigned FRAME_CLKS = 2 * N * CD;

  logic         clk, rst_n, enable, up_down, load;
  logic [W-1:0] load_val, count;
  logic         cs, sclk, sdo, busy, frame_done;

  int vectors     = 0;
  int miscompares = 0;

  spi_counter_tx #(.WIDTH(W), .CLK_DIV(CD), .GAP(GP), .CPOL(CP)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .up_down(up_down),
    .load(load), .load_val(load_val), .count(count), .cs(cs),
    .sclk(sclk), .sdo(sdo), .busy(busy), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] bits;
    int          nbits;
    int          len;
    int          gap;
    logic        fd;
  } frame_t;

  frame_t frames[$];
  int     cs_falls = 0;
  int     fd_err   = 0;
  int     busy_err = 0;
  int     idle_err = 0;

  // Frame decoder sampling mid-cycle; a reset discards any partial frame.
  logic   m_prev_cs, m_prev_sck, m_in_frame;
  frame_t m_cur;
  int     m_high;
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_prev_cs  = 1'b1;
      m_prev_sck = 1'b0;
      m_in_frame = 1'b0;
      m_high     = 0;
      frames.delete();
    end else begin
      if (frame_done !== (m_prev_cs === 1'b0 && cs === 1'b1)) fd_err++;
      if (busy !== ~cs) busy_err++;
      if (cs === 1'b1 && sclk !== CP) idle_err++;
      if (m_prev_cs === 1'b1 && cs === 1'b0) begin
        cs_falls++;
        m_in_frame  = 1'b1;
        m_cur.bits  = '0;
        m_cur.nbits = 0;
        m_cur.len   = 1;
        m_cur.gap   = m_high;
        m_cur.fd    = 1'b0;
        m_high      = 0;
      end else if (cs === 1'b0) begin
        m_cur.len++;
      end
      if (cs === 1'b1) m_high++;
      if (cs === 1'b0 && m_prev_sck === 1'b0 && (sclk ^ CP) === 1'b1) begin
        m_cur.bits = {m_cur.bits[30:0], sdo};
        m_cur.nbits++;
      end
      if (m_in_frame && m_prev_cs === 1'b0 && cs === 1'b1) begin
        m_cur.fd   = frame_done;
        frames.push_back(m_cur);
        m_in_frame = 1'b0;
      end
      m_prev_cs  = cs;
      m_prev_sck = sclk ^ CP;
    end
  end

  // Expected serial bit string for a snapshot value.
  function automatic logic [31:0] exp_bits(input logic [W-1:0] v);
    logic [31:0] r;
    r = 32'(v);
`ifdef SPI_COUNTER_PARITY_EN
    r = {r[30:0], ^v};
`endif
    return r;
  endfunction

  function automatic logic [W-1:0] stepped(input logic [W-1:0] v, input bit up);
    return up ? W'(v + 1) : W'(v - 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_value(input logic [W-1:0] v);
    load     = 1'b1;
    load_val = v;
    tick();
    load     = 1'b0;
  endtask

  task automatic wait_cs_low(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (cs === 1'b0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL cs_fall_timeout: cs=%b required 0 within 300 clks", cs);
    end
  endtask

  task automatic get_frame(output frame_t f, output bit ok);
    ok = 1'b0;
    f  = '{bits: '0, nbits: 0, len: 0, gap: 0, fd: 1'b0};
    for (int i = 0; i < 1000; i++) begin
      if (frames.size() > 0) begin
        f  = frames.pop_front();
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL frame_timeout: no frame completed within 1000 clks");
    end
  endtask

  task automatic start_one_frame(input bit up);
    bit ok;
    up_down = up;
    enable  = 1'b1;
    wait_cs_low(ok);
    enable  = 1'b0;
  endtask

  task automatic settle();
    enable = 1'b0;
    repeat (FRAME_CLKS + GP + 4) tick();
    frames.delete();
  endtask

  task automatic test_reset();
    frame_t f;
    bit     ok;
    rst_n = 1'b0; enable = 1'b1; up_down = 1'b1; load = 1'b0; load_val = '0;
    repeat (3) tick();
    vectors += 6;
    if (cs !== 1'b1)         begin miscompares++; $display("FAIL reset_cs: got %b want 1", cs); end
    if (sclk !== CP)         begin miscompares++; $display("FAIL reset_sclk: got %b want %b", sclk, CP); end
    if (sdo !== 1'b0)        begin miscompares++; $display("FAIL reset_sdo: got %b want 0", sdo); end
    if (count !== '0)        begin miscompares++; $display("FAIL reset_count: got %h want 00", count); end
    if (busy !== 1'b0)       begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (frame_done !== 1'b0) begin miscompares++; $display("FAIL reset_fd: got %b want 0", frame_done); end
    rst_n = 1'b1;
    vectors++;
    if (cs !== 1'b1) begin miscompares++; $display("FAIL release_cs_early: got %b want 1", cs); end
    tick();
    vectors += 2;
    if (cs !== 1'b0)   begin miscompares++; $display("FAIL first_cs_fall: got %b want 0", cs); end
    if (busy !== 1'b1) begin miscompares++; $display("FAIL first_busy: got %b want 1", busy); end
    enable = 1'b0;
    get_frame(f, ok);
    if (ok) begin
      vectors += 2;
      if (f.bits !== exp_bits(8'h00)) begin miscompares++; $display("FAIL first_frame_bits: got %h want %h", f.bits, exp_bits(8'h00)); end
      if (count !== 8'h01)            begin miscompares++; $display("FAIL first_frame_count: got %h want 01", count); end
    end
    settle();
  endtask

  task automatic test_basic_frame(input logic [W-1:0] v);
    frame_t f;
    bit     ok;
    load_value(v);
    start_one_frame(1'b1);
    get_frame(f, ok);
    if (ok) begin
      vectors += 5;
      if (f.bits !== exp_bits(v)) begin miscompares++; $display("FAIL basic_bits[%h]: got %h want %h", v, f.bits, exp_bits(v)); end
      if (f.nbits != N)           begin miscompares++; $display("FAIL basic_nbits[%h]: got %0d want %0d", v, f.nbits, N); end
      if (f.len != FRAME_CLKS)    begin miscompares++; $display("FAIL basic_cs_low[%h]: got %0d want %0d", v, f.len, FRAME_CLKS); end
      if (f.fd !== 1'b1)          begin miscompares++; $display("FAIL basic_frame_done[%h]: got %b want 1", v, f.fd); end
      if (count !== stepped(v, 1'b1)) begin miscompares++; $display("FAIL basic_count[%h]: got %h want %h", v, count, stepped(v, 1'b1)); end
    end
    settle();
  endtask

  task automatic test_back_to_back();
    frame_t     f;
    bit         ok;
    logic [W-1:0] exp_v;
    load_value(8'h10);
    up_down = 1'b1;
    enable  = 1'b1;
    exp_v   = 8'h10;
    for (int i = 0; i < 3; i++) begin
      get_frame(f, ok);
      if (i == 2) enable = 1'b0;
      if (ok) begin
        vectors++;
        if (f.bits !== exp_bits(exp_v)) begin miscompares++; $display("FAIL b2b_bits[%0d]: got %h want %h", i, f.bits, exp_bits(exp_v)); end
        if (i > 0) begin
          vectors++;
          if (f.gap != GP + 1) begin miscompares++; $display("FAIL b2b_gap[%0d]: got %0d want %0d", i, f.gap, GP + 1); end
        end
      end
      exp_v = stepped(exp_v, 1'b1);
    end
    settle();
    vectors++;
    if (count !== 8'h13) begin miscompares++; $display("FAIL b2b_count: got %h want 13", count); end
  endtask

  task automatic test_wrap();
    frame_t f;
    bit     ok;
    load_value(8'hFF);
    start_one_frame(1'b1);
    get_frame(f, ok);
    vectors++;
    if (count !== 8'h00) begin miscompares++; $display("FAIL wrap_up: got %h want 00", count); end
    settle();
    start_one_frame(1'b0);
    get_frame(f, ok);
    if (ok) begin
      vectors++;
      if (f.bits !== exp_bits(8'h00)) begin miscompares++; $display("FAIL wrap_down_bits: got %h want %h", f.bits, exp_bits(8'h00)); end
    end
    vectors++;
    if (count !== 8'hFF) begin miscompares++; $display("FAIL wrap_down: got %h want FF", count); end
    settle();
    // Load lands on the frame-end cycle and must override the step.
    load_value(8'h40);
    start_one_frame(1'b1);
    repeat (FRAME_CLKS - 1) tick();
    load = 1'b1; load_val = 8'h33;
    tick();
    load = 1'b0;
    vectors += 3;
    if (cs !== 1'b1)         begin miscompares++; $display("FAIL endload_cs: got %b want 1", cs); end
    if (frame_done !== 1'b1) begin miscompares++; $display("FAIL endload_fd: got %b want 1", frame_done); end
    if (count !== 8'h33)     begin miscompares++; $display("FAIL endload_count: got %h want 33", count); end
    get_frame(f, ok);
    if (ok) begin
      vectors++;
      if (f.bits !== exp_bits(8'h40)) begin miscompares++; $display("FAIL endload_bits: got %h want %h", f.bits, exp_bits(8'h40)); end
    end
    settle();
  endtask

  task automatic test_random();
    frame_t       f;
    bit           ok, up;
    logic [W-1:0] v1, v2;
    for (int i = 0; i < 6; i++) begin
      v1 = W'($urandom);
      v2 = W'($urandom);
      up = 1'($urandom_range(0, 1));
      load_value(v1);
      start_one_frame(up);
      // Odd iterations also reload mid-frame; the frame keeps its snapshot.
      if (i % 2 == 1) begin
        repeat (5 + $urandom_range(0, 10)) tick();
        load_value(v2);
      end else begin
        v2 = v1;
      end
      get_frame(f, ok);
      if (ok) begin
        vectors += 2;
        if (f.bits !== exp_bits(v1)) begin miscompares++; $display("FAIL rand_bits[%0d]: got %h want %h", i, f.bits, exp_bits(v1)); end
        if (f.len != FRAME_CLKS)     begin miscompares++; $display("FAIL rand_cs_low[%0d]: got %0d want %0d", i, f.len, FRAME_CLKS); end
      end
      vectors++;
      if (count !== stepped(v2, up)) begin miscompares++; $display("FAIL rand_count[%0d]: got %h want %h", i, count, stepped(v2, up)); end
      settle();
    end
  endtask

  task automatic test_enable_drop();
    frame_t f;
    bit     ok;
    int     falls;
    load_value(8'h3C);
    up_down = 1'b0;
    enable  = 1'b1;
    wait_cs_low(ok);
    repeat (6 * CD + 1) tick();
    enable = 1'b0;
    get_frame(f, ok);
    if (ok) begin
      vectors += 2;
      if (f.bits !== exp_bits(8'h3C)) begin miscompares++; $display("FAIL drop_bits: got %h want %h", f.bits, exp_bits(8'h3C)); end
      if (f.len != FRAME_CLKS)        begin miscompares++; $display("FAIL drop_cs_low: got %0d want %0d", f.len, FRAME_CLKS); end
    end
    vectors++;
    if (count !== 8'h3B) begin miscompares++; $display("FAIL drop_count: got %h want 3B", count); end
    falls = cs_falls;
    repeat (200) tick();
    vectors++;
    if (cs_falls != falls) begin miscompares++; $display("FAIL drop_no_new_frame: got %0d falls want %0d", cs_falls, falls); end
  endtask

  task automatic test_reset_mid();
    frame_t f;
    bit     ok;
    load_value(8'h77);
    up_down = 1'b1;
    enable  = 1'b1;
    wait_cs_low(ok);
    repeat (8 * CD + 1) tick();
    rst_n = 1'b0;
    #1;
    vectors += 4;
    if (cs !== 1'b1)    begin miscompares++; $display("FAIL midrst_cs: got %b want 1", cs); end
    if (sclk !== CP)    begin miscompares++; $display("FAIL midrst_sclk: got %b want %b", sclk, CP); end
    if (count !== '0)   begin miscompares++; $display("FAIL midrst_count: got %h want 00", count); end
    if (busy !== 1'b0)  begin miscompares++; $display("FAIL midrst_busy: got %b want 0", busy); end
    #2;
    rst_n = 1'b1;
    wait_cs_low(ok);
    enable = 1'b0;
    get_frame(f, ok);
    if (ok) begin
      vectors++;
      if (f.bits !== exp_bits(8'h00)) begin miscompares++; $display("FAIL midrst_restart_bits: got %h want %h", f.bits, exp_bits(8'h00)); end
    end
    vectors++;
    if (count !== 8'h01) begin miscompares++; $display("FAIL midrst_restart_count: got %h want 01", count); end
    settle();
  endtask

  task automatic test_status();
    vectors += 3;
    if (fd_err != 0)   begin miscompares++; $display("FAIL status_frame_done: got %0d bad cycles want 0", fd_err); end
    if (busy_err != 0) begin miscompares++; $display("FAIL status_busy: got %0d bad cycles want 0", busy_err); end
    if (idle_err != 0) begin miscompares++; $display("FAIL status_sclk_idle: got %0d bad cycles want 0", idle_err); end
  endtask

  initial begin
    test_reset();
    test_basic_frame(8'hA5);
    test_basic_frame(8'h07);
    test_back_to_back();
    test_wrap();
    test_random();
    test_enable_drop();
    test_reset_mid();
    test_status();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/spi_counter_tx.md
Name: spi_counter_tx

Overview:
Parametrised free-running up/down counter that serialises its current value over a 3-wire SPI master link (cs, sclk, sdo) once per frame, then steps the count.
- Successor to the fixed-width serial counter; adds width, SCLK divider, inter-frame gap, clock polarity, direction, parallel load and status outputs.
- Drives a serial display/DAC/shift-register chain directly from fabric.

Parameters:
WIDTH, 16, counter and frame data width in bits (≥2)
CLK_DIV, 4, clk cycles per SCLK half-period (≥1)
GAP, 8, extra clk cycles cs is held high between frames (≥0)
CPOL, 0, SCLK idle level; data timing unchanged (mode 0 when 0, mode 2 when 1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
enable  in  1  high: start/continue frames; low: stop after current frame
up_down  in  1  1 = increment, 0 = decrement at frame end
load  in  1  synchronous load strobe
load_val  in  WIDTH  value written to count on load
count  out  WIDTH  current counter value
cs  out  1  chip select, active low
sclk  out  1  serial clock
sdo  out  1  serial data, MSB first
busy  out  1  high while cs low
frame_done  out  1  one-clk pulse on the cycle cs returns high

Behaviour:
- Reset (asynchronous, immediate, including mid-frame): cs=1, sclk=CPOL, sdo=0, count=0, busy=0, frame_done=0, FSM=IDLE, divider and bit counters cleared.
- FSM states: IDLE, SHIFT, GAP.
- IDLE:
  - Samples enable each cycle.
  - On enable=1, snapshots count into the shift register.
  - Next cycle (T0): cs=0, busy=1, sdo=MSB, internal sclk low. Go to SHIFT.
- SHIFT:
  - Internal sclk toggles every CLK_DIV clks.
  - Rising edges occur at T0+CLK_DIV+2k·CLK_DIV, for k=0..N-1.
  - sdo changes only on internal falling edges, T0+2k·CLK_DIV, for k=1..N-1. Data is stable for the whole high phase.
  - N = WIDTH.
  - At T0+2N·CLK_DIV: internal sclk low, cs=1, busy=0, sdo=0, frame_done=1 for one cycle, count steps. Go to GAP.
- GAP: holds cs=1 for GAP clks, then IDLE. Minimum cs-high time between frames = GAP+1 clks.
- sclk output = internal sclk XOR CPOL.
- Count step: ±1 modulo 2^WIDTH. Wraps 2^WIDTH-1→0 (up) and 0→2^WIDTH-1 (down). up_down is sampled on the step cycle.
- load:
  - Accepted in any state. count=load_val on the next clock.
  - Never alters a frame in flight, because the frame transmits its snapshot.
  - load coincident with the frame-end step: load wins, no step.
- enable deasserted mid-frame: current frame completes normally, including the count step. No new cs falling edge.
- enable toggling during GAP has no effect until IDLE.

Optional Feature:
SPI_COUNTER_PARITY_EN
- Defined: frame carries N = WIDTH+1 bits. The final bit is even parity over the snapshot (XOR of all bits). cs-low time = 2(WIDTH+1)·CLK_DIV.
- Undefined: N = WIDTH and no parity logic is present.

Test Plan:
All scenarios use WIDTH=8, CLK_DIV=2, GAP=4, CPOL=0 unless noted.
1. rst_n=0 with enable=1 → cs=1, sclk=0, sdo=0, count=0x00, busy=0. After release, first cs fall comes one clk after enable is seen in IDLE.
2. load 0xA5, up_down=1, enable=1 → sdo sampled on 8 sclk rises = 1,0,1,0,0,1,0,1. cs low exactly 32 clks. frame_done single pulse as cs rises. count=0xA6. Next cs fall ≥5 clks later.
3. Wrap: load 0xFF, up_down=1, one frame → count=0x00. Then up_down=0, one frame → count=0xFF. Also load 0x33 on the frame-end cycle → count=0x33, not stepped.
4. enable dropped during 4th bit → remaining 4 bits and count step complete. No further cs falling edge over 200 clks.
5. rst_n pulsed low mid-frame (bit 5) → cs=1, sclk=0, count=0 in the same cycle. Restart sends 0x00.
6. SPI_COUNTER_PARITY_EN, CPOL=1 → sclk idles 1. 0xA5 sends 9th bit 0 with cs low 36 clks. 0x07 sends 9th bit 1.
